// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Brief    : Feeds a small program buffer into the bus processor one
//            instruction at a time, with mvi immediates, stop and halt.
//            Optional watchdog selected by the macro PSEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer #(
  parameter int         REG_WIDTH         = 16,
  parameter int         INSTRUCTION_WIDTH = 9,
  parameter int         DEPTH             = 16,
  parameter int         ADDR_WIDTH        = 4,
  parameter logic [2:0] MVI_OPCODE        = 3'b001,
  parameter int         WDOG_CYCLES       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  proc_done,
  output logic                  proc_run,
  output logic [REG_WIDTH-1:0]  proc_din,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [7:0]            instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [REG_WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   w_len_nxt;
  logic [7:0]            r_count;
  logic [7:0]            w_count_nxt;
  logic                  r_halted;
  logic                  w_halted_nxt;
  logic                  r_stop_pending;
  logic                  w_stop_nxt;
  logic                  w_run;
  logic [REG_WIDTH-1:0]  w_din;
  logic [REG_WIDTH-1:0]  w_cur;
  logic [REG_WIDTH-1:0]  w_imm;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH:0]   w_pc_next;
  logic                  w_is_mvi;
  logic                  w_busy;

`ifdef PSEQ_WDOG_EN
  localparam int                c_WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);
  logic                r_err;
  logic                w_err_nxt;
  logic [c_WDOG_W-1:0] r_wdog;
  logic [c_WDOG_W-1:0] w_wdog_nxt;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = ^WDOG_CYCLES;
`endif

  // Buffer is deliberately outside the reset domain so a reset keeps the program
  always_ff @(posedge clk) begin
    if (wr_en && !w_busy) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign w_cur     = r_mem[r_pc];
  assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
  assign w_imm     = r_mem[w_pc_inc];
  assign w_is_mvi  = (w_cur[INSTRUCTION_WIDTH-1 -: 3] == MVI_OPCODE);
  assign w_pc_next = {1'b0, r_pc} + (w_is_mvi ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1));
  assign w_busy    = (r_state == S_ISSUE) || (r_state == S_WAIT);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_len_nxt    = r_len;
    w_count_nxt  = r_count;
    w_halted_nxt = r_halted;
    w_stop_nxt   = r_stop_pending;
    w_run        = 1'b0;
    w_din        = '0;
`ifdef PSEQ_WDOG_EN
    w_err_nxt    = r_err;
    w_wdog_nxt   = r_wdog;
`endif
    case (r_state)
      S_ISSUE: begin
        w_run       = 1'b1;
        w_din       = w_cur;
        w_state_nxt = S_WAIT;
        if (stop) w_stop_nxt = 1'b1;
`ifdef PSEQ_WDOG_EN
        w_wdog_nxt  = '0;
`endif
      end
      S_WAIT: begin
        if (w_is_mvi) w_din = w_imm;
        if (stop) w_stop_nxt = 1'b1;
        if (proc_done) begin
          w_pc_nxt = w_pc_next[ADDR_WIDTH-1:0];
          if (r_count != 8'hFF) w_count_nxt = r_count + 8'd1;
          // End test uses the unwrapped pc so a full 16-word program terminates
          if (r_stop_pending || (w_pc_next >= r_len)) begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
            w_stop_nxt   = 1'b0;
          end else begin
            w_state_nxt  = S_ISSUE;
          end
        end
`ifdef PSEQ_WDOG_EN
        else if (r_wdog == c_WDOG_LAST) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end else begin
          w_wdog_nxt  = r_wdog + c_WDOG_W'(1);
        end
`endif
      end
      default: begin
        if (start) begin
          w_len_nxt    = prog_len;
          w_pc_nxt     = '0;
          w_count_nxt  = '0;
          w_halted_nxt = 1'b0;
          w_stop_nxt   = 1'b0;
`ifdef PSEQ_WDOG_EN
          w_err_nxt    = 1'b0;
`endif
          if (prog_len == '0) begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_ISSUE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_pc           <= '0;
      r_len          <= '0;
      r_count        <= '0;
      r_halted       <= 1'b0;
      r_stop_pending <= 1'b0;
`ifdef PSEQ_WDOG_EN
      r_err          <= 1'b0;
      r_wdog         <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_len          <= w_len_nxt;
      r_count        <= w_count_nxt;
      r_halted       <= w_halted_nxt;
      r_stop_pending <= w_stop_nxt;
`ifdef PSEQ_WDOG_EN
      r_err          <= w_err_nxt;
      r_wdog         <= w_wdog_nxt;
`endif
    end
  end

  assign proc_run    = w_run;
  assign proc_din    = w_din;
  assign busy        = w_busy;
  assign halted      = r_halted;
  assign pc          = r_pc;
  assign instr_count = r_count;
`ifdef PSEQ_WDOG_EN
  assign err         = r_err;
`else
  assign err         = 1'b0;
`endif

endmodule
`default_nettype wire
